// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin whole-burst arbiter onto the vga_adapter pixel port, clipping off-screen pixels
`timescale 1ns/1ps
module plot_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*7-1:0] req_y,
  input  logic [NUM_REQ*3-1:0] req_colour,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic [7:0]           drop_count
);
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_BURST = 1'b1;
  logic       r_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_owner;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic [7:0] r_drop;
  logic [3:0]  w_valid;
  logic [3:0]  w_lastv;
  logic [3:0]  w_ready;
  logic [31:0] w_xs;
  logic [27:0] w_ys;
  logic [11:0] w_cs;
  logic [7:0]  w_x;
  logic [6:0]  w_y;
  logic [2:0]  w_c;
  logic [1:0]  w_sel;
  logic        w_any;
  logic        w_xfer;
  logic        w_last;
  logic        w_on;
  function automatic logic [1:0] wrap(input logic [2:0] s);
    return (s >= 3'(NUM_REQ)) ? 2'(s - 3'(NUM_REQ)) : s[1:0];
  endfunction
  assign w_valid = 4'(req_valid);
  assign w_lastv = 4'(req_last);
  assign w_xs    = 32'(req_x);
  assign w_ys    = 28'(req_y);
  assign w_cs    = 12'(req_colour);
  assign w_x     = w_xs[8*r_owner +: 8];
  assign w_y     = w_ys[7*r_owner +: 7];
  assign w_c     = w_cs[3*r_owner +: 3];
  assign w_any   = |req_valid;
  assign w_xfer  = (r_state == S_BURST) && w_valid[r_owner];
  assign w_last  = w_lastv[r_owner];
  assign w_on    = (w_x < 8'd160) && (w_y < 7'd120);
  assign w_ready = (r_state == S_BURST) ? (4'b0001 << r_owner) : 4'b0000;
  always_comb begin
    w_sel = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_valid[wrap({1'b0, r_rr_ptr} + 3'(k))]) w_sel = wrap({1'b0, r_rr_ptr} + 3'(k));
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= 2'd0;
      r_owner  <= 2'd0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      r_plot <= w_xfer && w_on;
      if (w_xfer && w_on) begin
        r_x      <= w_x;
        r_y      <= w_y;
        r_colour <= w_c;
      end
      if (w_xfer && !w_on && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_owner <= w_sel;
          r_state <= S_BURST;
        end
      end else if (w_xfer && w_last) begin
        r_state  <= S_IDLE;
        r_rr_ptr <= wrap({1'b0, r_owner} + 3'd1);
      end
    end
  end
  assign req_ready  = w_ready[NUM_REQ-1:0];
  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign busy       = r_state;
  assign owner      = r_owner;
  assign drop_count = r_drop;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed scenarios driving per-requester pixel queues with a per-owner plot scoreboard
`timescale 1ns/1ps
module tb_plot_arbiter;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pkt_t;
  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  req_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  drop_count;
  pkt_t        src[4][$];
  pkt_t        exp_q[4][$];
  logic [1:0]  grant_log[$];
  time         plot_t[$];
  logic [3:0]  pause;
  int          pass = 0;
  int          total = 0;
  int          plot_cnt = 0;

  plot_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .req_ready(req_ready),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .owner(owner), .drop_count(drop_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input int i, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc, input logic pl);
    src[i].push_back(pkt_t'{px, py, pc, pl});
    if (px < 8'd160 && py < 7'd120) exp_q[i].push_back(pkt_t'{px, py, pc, pl});
  endtask

  function automatic logic [31:0] gpack();
    logic [31:0] v = '0;
    foreach (grant_log[k]) v[2*k +: 2] = grant_log[k];
    return v;
  endfunction

  function automatic logic pending();
    return (src[0].size() + src[1].size() + src[2].size() + src[3].size() != 0) || busy;
  endfunction

  task automatic rst_on();
    @(negedge clk);
    resetn = 0;
    pause = 0;
    grant_log.delete();
    plot_t.delete();
  endtask

  task automatic rst_off();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  // requester models: hold the queue head until it is accepted
  initial begin
    logic [3:0] xf;
    xf = 0;
    req_valid = 0; req_last = 0; req_x = 0; req_y = 0; req_colour = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (xf[i] && resetn) void'(src[i].pop_front());
        req_valid[i] = (src[i].size() != 0) && !pause[i];
        if (src[i].size() != 0) begin
          req_x[8*i +: 8]      = src[i][0].x;
          req_y[7*i +: 7]      = src[i][0].y;
          req_colour[3*i +: 3] = src[i][0].c;
          req_last[i]          = src[i][0].last;
        end
      end
      @(negedge clk);
      xf = req_valid & req_ready;
    end
  end

  initial begin
    logic pb;
    pkt_t e;
    pb = 0;
    forever begin
      @(negedge clk);
      if (plot) begin
        plot_cnt++;
        plot_t.push_back($time);
        chk("sb_expected", 32'(exp_q[owner].size() != 0), 32'd1);
        if (exp_q[owner].size() != 0) begin
          e = exp_q[owner].pop_front();
          chk("sb_pixel", 32'({x, y, colour}), 32'({e.x, e.y, e.c}));
        end
      end
      if (busy && !pb) grant_log.push_back(owner);
      pb = busy;
    end
  end

  initial begin
    logic [9:0] rp, bp, pp;
    int n0, n;
    resetn = 1;
    pause = 0;
    #1 resetn = 0;
    #1;
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    // single 3-pixel burst from req0
    send(0, 8'd10, 7'd5, 3'd1, 1'b0);
    send(0, 8'd11, 7'd5, 3'd1, 1'b0);
    send(0, 8'd12, 7'd5, 3'd1, 1'b1);
    rst_off();
    rp = 0; bp = 0; pp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rp[k] = req_ready[0];
      bp[k] = busy;
      pp[k] = plot;
    end
    chk("s1_ready", 32'(rp), 32'b00000111);
    chk("s1_busy", 32'(bp), 32'b00000111);
    chk("s1_plot", 32'(pp), 32'b00001110);
    wait_idle("s1_idle", 20);
    chk("s1_grants", gpack(), 32'd0);
    chk("s1_ngrants", 32'(grant_log.size()), 32'd1);
    // round robin between req1 and req3
    rst_on();
    send(1, 8'd20, 7'd1, 3'd2, 1'b0);
    send(1, 8'd21, 7'd1, 3'd2, 1'b1);
    send(1, 8'd22, 7'd1, 3'd2, 1'b0);
    send(1, 8'd23, 7'd1, 3'd2, 1'b1);
    send(3, 8'd30, 7'd2, 3'd3, 1'b0);
    send(3, 8'd31, 7'd2, 3'd3, 1'b1);
    rst_off();
    bp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bp[k] = busy;
    end
    chk("s2_busy", 32'(bp), 32'b0011011011);
    wait_idle("s2_idle", 30);
    chk("s2_grants", gpack(), 32'h1D);
    chk("s2_ngrants", 32'(grant_log.size()), 32'd3);
    // clipping and drop counter saturation on req2
    rst_on();
    send(2, 8'd160, 7'd0, 3'd4, 1'b0);
    send(2, 8'd0, 7'd120, 3'd4, 1'b0);
    send(2, 8'd159, 7'd119, 3'd5, 1'b1);
    rst_off();
    n0 = plot_cnt;
    wait_idle("s3_idle", 20);
    chk("s3_drop", 32'(drop_count), 32'd2);
    chk("s3_plots", 32'(plot_cnt - n0), 32'd1);
    for (int k = 0; k < 300; k++) send(2, 8'(160 + k % 96), 7'(k % 128), 3'(k), 1'b1);
    n0 = plot_cnt;
    wait_idle("s3_sat_idle", 700);
    chk("s3_drop_sat", 32'(drop_count), 32'hFF);
    chk("s3_sat_plots", 32'(plot_cnt - n0), 32'd0);
    // owner stall keeps the lock
    rst_on();
    send(0, 8'd40, 7'd10, 3'd6, 1'b0);
    send(0, 8'd41, 7'd10, 3'd6, 1'b0);
    send(0, 8'd42, 7'd10, 3'd6, 1'b0);
    send(0, 8'd43, 7'd10, 3'd6, 1'b1);
    send(1, 8'd50, 7'd20, 3'd7, 1'b1);
    rst_off();
    repeat (2) @(negedge clk);
    pause[0] = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s4_lock_ready", 32'(req_ready), 32'b0001);
    end
    pause[0] = 0;
    bp = 0; rp = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bp[k] = busy;
      rp[k] = req_ready[1];
    end
    chk("s4_busy", 32'(bp), 32'b01011);
    chk("s4_ready1", 32'(rp), 32'b01000);
    wait_idle("s4_idle", 20);
    chk("s4_grants", gpack(), 32'd4);
    chk("s4_ngrants", 32'(grant_log.size()), 32'd2);
    // reset mid-burst: first move the pointer to 3 so a fresh scan is observable
    send(2, 8'd60, 7'd30, 3'd1, 1'b1);
    wait_idle("s5_pre_idle", 20);
    for (int k = 0; k < 6; k++) send(2, 8'(70 + k), 7'd40, 3'd2, k == 5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!plot && n < 20);
    chk("s5_plot_seen", 32'(plot), 32'd1);
    #2 resetn = 0;
    #1;
    chk("s5_async_plot", 32'(plot), 32'd0);
    chk("s5_async_x", 32'(x), 32'd0);
    chk("s5_async_y", 32'(y), 32'd0);
    chk("s5_async_colour", 32'(colour), 32'd0);
    chk("s5_async_busy", 32'(busy), 32'd0);
    chk("s5_async_ready", 32'(req_ready), 32'd0);
    chk("s5_async_owner", 32'(owner), 32'd0);
    src[2].delete();
    exp_q[2].delete();
    grant_log.delete();
    send(2, 8'd80, 7'd50, 3'd3, 1'b1);
    send(3, 8'd90, 7'd60, 3'd4, 1'b1);
    rst_off();
    wait_idle("s5_idle", 20);
    chk("s5_grants", gpack(), 32'd14);
    chk("s5_ngrants", 32'(grant_log.size()), 32'd2);
    // single-pixel bursts alternate with one bubble each
    rst_on();
    for (int k = 0; k < 4; k++) begin
      send(0, 8'(100 + k), 7'd70, 3'd1, 1'b1);
      send(1, 8'(110 + k), 7'd71, 3'd2, 1'b1);
    end
    rst_off();
    wait_idle("s6_idle", 40);
    chk("s6_grants", gpack(), 32'h4444);
    chk("s6_ngrants", 32'(grant_log.size()), 32'd8);
    chk("s6_nplots", 32'(plot_t.size()), 32'd8);
    for (int k = 1; k < plot_t.size(); k++) chk("s6_plot_gap", 32'(plot_t[k] - plot_t[k-1]), 32'd20);
    for (int i = 0; i < 4; i++) chk("sb_drained", 32'(exp_q[i].size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
